// File: rtl/mul_ctrl.sv
// Sequencer for the wavelet multiply datapath: load one FFT frame, multiply it by J1 daughter wavelets, stream each product set.
// Start-to-done N + J1*(2N+MUL_LAT) + 1 cycles plus stalls; load paced by in_valid_i, stream holds its beat while out_ready_i is low.
module mul_ctrl #(
  parameter int N       = 1024,
  parameter int J1      = 256,
  parameter int MUL_LAT = 3,
  localparam int AW     = $clog2(N),
  localparam int SW     = (J1 > 1) ? $clog2(J1) : 1,
  localparam int DW     = AW + SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          bram_res_en_o,
  output logic          bram_res_we_o,
  output logic [AW-1:0] bram_res_addr_o,
  output logic [DW-1:0] daughter_addr_o,
  output logic          bram_mul_en_o,
  output logic          bram_mul_we_o,
  output logic [AW-1:0] bram_mul_addr_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic [SW-1:0] out_scale_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_STREAM,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] k;
  logic [SW-1:0] scale;
  logic          draining;
  logic [MUL_LAT-1:0] sr_vld;
  logic [AW-1:0]      sr_addr [MUL_LAT];

  logic k_last;
  logic scale_last;
  logic issue;
  logic wr_vld;
  logic mul_end;

  assign k_last     = (k == AW'(N - 1));
  assign scale_last = (scale == SW'(J1 - 1));
  assign issue      = (state == S_MUL) && !draining;
  assign wr_vld     = (state == S_MUL) && sr_vld[MUL_LAT-1];
  // The phase ends on the cycle that writes the final product, not when issuing stops.
  assign mul_end    = wr_vld && (sr_addr[MUL_LAT-1] == AW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_LOAD;
      S_LOAD:   if (in_valid_i && k_last) state_nxt = S_MUL;
      S_MUL:    if (mul_end) state_nxt = S_STREAM;
      S_STREAM: if (out_ready_i && k_last) state_nxt = scale_last ? S_DONE : S_MUL;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      scale    <= '0;
      draining <= 1'b0;
      sr_vld   <= '0;
      for (int i = 0; i < MUL_LAT; i++) sr_addr[i] <= '0;
    end else begin
      // {valid, addr} delay line tracking reads in flight through the multiplier
      sr_vld[0]  <= issue;
      sr_addr[0] <= k;
      for (int i = 1; i < MUL_LAT; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_addr[i] <= sr_addr[i-1];
      end
      case (state)
        S_IDLE: begin
          if (start_i) begin
            k        <= '0;
            scale    <= '0;
            draining <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid_i) k <= k_last ? '0 : k + AW'(1);
        end
        S_MUL: begin
          if (issue) begin
            k <= k_last ? '0 : k + AW'(1);
            if (k_last) draining <= 1'b1;
          end
          if (mul_end) begin
            k        <= '0;
            draining <= 1'b0;
          end
        end
        S_STREAM: begin
          if (out_ready_i) begin
            if (k_last) begin
              k <= '0;
              if (!scale_last) scale <= scale + SW'(1);
            end else begin
              k <= k + AW'(1);
            end
          end
        end
        S_DONE: begin
          k     <= '0;
          scale <= '0;
        end
        default: k <= '0;
      endcase
    end
  end

  always_comb begin
    busy_o          = 1'b0;
    done_o          = 1'b0;
    in_ready_o      = 1'b0;
    bram_res_en_o   = 1'b0;
    bram_res_we_o   = 1'b0;
    bram_res_addr_o = '0;
    daughter_addr_o = '0;
    bram_mul_en_o   = 1'b0;
    bram_mul_we_o   = 1'b0;
    bram_mul_addr_o = '0;
    out_valid_o     = 1'b0;
    out_last_o      = 1'b0;
    out_scale_o     = '0;
    case (state)
      S_LOAD: begin
        busy_o          = 1'b1;
        in_ready_o      = 1'b1;
        bram_res_en_o   = in_valid_i;
        bram_res_we_o   = in_valid_i;
        bram_res_addr_o = k;
      end
      S_MUL: begin
        busy_o = 1'b1;
        if (!draining) begin
          bram_res_en_o   = 1'b1;
          bram_res_addr_o = k;
          daughter_addr_o = {scale, k};
        end
        bram_mul_en_o   = wr_vld;
        bram_mul_we_o   = wr_vld;
        bram_mul_addr_o = wr_vld ? sr_addr[MUL_LAT-1] : '0;
      end
      S_STREAM: begin
        busy_o          = 1'b1;
        bram_mul_en_o   = 1'b1;
        bram_mul_addr_o = k;
        out_valid_o     = 1'b1;
        out_last_o      = k_last;
        out_scale_o     = scale;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        done_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: emulates the BRAMs, daughter ROM and multiplier around the controller and
// scores every write, issue and streamed product against sample*coefficient arithmetic.
module tb_mul_ctrl;
  localparam int N  = 8;
  localparam int J1 = 2;
  localparam int L  = 3;
  localparam int AW = 3;
  localparam int SW = 1;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          bram_res_en_o;
  logic          bram_res_we_o;
  logic [AW-1:0] bram_res_addr_o;
  logic [DW-1:0] daughter_addr_o;
  logic          bram_mul_en_o;
  logic          bram_mul_we_o;
  logic [AW-1:0] bram_mul_addr_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          out_last_o;
  logic [SW-1:0] out_scale_o;

  always #5 clk = ~clk;

  mul_ctrl #(.N(N), .J1(J1), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .bram_res_en_o(bram_res_en_o), .bram_res_we_o(bram_res_we_o), .bram_res_addr_o(bram_res_addr_o),
    .daughter_addr_o(daughter_addr_o),
    .bram_mul_en_o(bram_mul_en_o), .bram_mul_we_o(bram_mul_we_o), .bram_mul_addr_o(bram_mul_addr_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o), .out_scale_o(out_scale_o)
  );

  logic [19:0] outs;
  assign outs = {busy_o, done_o, in_ready_o, bram_res_en_o, bram_res_we_o, bram_res_addr_o,
                 daughter_addr_o, bram_mul_en_o, bram_mul_we_o, bram_mul_addr_o,
                 out_valid_o, out_last_o, out_scale_o};

  function automatic logic [15:0] rom(input int a);
    return 16'(a * 997 + 31);
  endfunction

  // Datapath stand-in: BRAMs and ROM act on the falling edge, multiplier is L stages deep.
  logic [15:0] din = '0;
  logic [15:0] res_mem [N];
  logic [31:0] mul_mem [N];
  logic [15:0] res_rd, rom_rd;
  logic [31:0] mul_rd;
  logic [31:0] pipe [L];

  always @(negedge clk) begin
    if (bram_res_en_o) begin
      if (bram_res_we_o) res_mem[bram_res_addr_o] <= din;
      else               res_rd <= res_mem[bram_res_addr_o];
    end
    rom_rd <= rom(int'(daughter_addr_o));
    if (bram_mul_en_o) begin
      if (bram_mul_we_o) mul_mem[bram_mul_addr_o] <= pipe[L-1];
      else               mul_rd <= mul_mem[bram_mul_addr_o];
    end
  end

  always @(posedge clk) begin
    pipe[0] <= res_rd * rom_rd;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] samples [N];
  int issue_cyc [N];
  int load_cnt, issue_cnt, wr_cnt, beat_k, beat_s, beats_total;
  int done_cnt, done_cyc, gap_cyc, stall_cyc, stall_run;
  bit prev_stall;
  logic [SW+AW+1+32-1:0] prev_beat, cur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    if (bram_res_en_o && bram_res_we_o) begin
      chk("res_wr_addr", bram_res_addr_o, load_cnt);
      chk("res_wr_valid", in_valid_i, 1);
      if (load_cnt < N) samples[load_cnt] = din;
      load_cnt++;
    end
    if (bram_res_en_o && !bram_res_we_o) begin
      chk("issue_addr", bram_res_addr_o, issue_cnt);
      chk("daughter_addr", daughter_addr_o, beat_s * N + issue_cnt);
      issue_cyc[bram_res_addr_o] = cyc;
      issue_cnt++;
    end
    if (bram_mul_en_o && bram_mul_we_o) begin
      chk("mul_wr_addr", bram_mul_addr_o, wr_cnt);
      chk("mul_wr_latency", cyc - issue_cyc[bram_mul_addr_o], L);
      wr_cnt++;
    end
    if (out_valid_o) begin
      cur = {out_scale_o, bram_mul_addr_o, out_last_o, mul_rd};
      if (prev_stall) chk("stall_hold", cur, prev_beat);
      if (beat_k == 0 && !prev_stall) begin
        chk("mul_wr_count", wr_cnt, N);
        chk("issue_count", issue_cnt, N);
        wr_cnt = 0;
        issue_cnt = 0;
      end
      if (out_ready_i) begin
        chk("beat_scale", out_scale_o, beat_s);
        chk("beat_addr", bram_mul_addr_o, beat_k);
        chk("beat_last", out_last_o, beat_k == N - 1);
        chk("beat_data", mul_rd, samples[beat_k] * rom(beat_s * N + beat_k));
        beats_total++;
        if (beat_k == N - 1) begin
          beat_k = 0;
          beat_s++;
        end else begin
          beat_k++;
        end
        prev_stall = 0;
      end else begin
        prev_stall = 1;
        prev_beat = cur;
        stall_cyc++;
      end
    end else begin
      prev_stall = 0;
    end
    if (in_ready_o && !in_valid_i) gap_cyc++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_busy_low", busy_o, 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous; 1: beats 2 and 5 stalled two cycles; 2: random gaps and stalls
  task automatic run_frame(input int mode, input bit spurious, input bit abort);
    int s_cyc;
    bit aborted;
    bit o_rdy, o_issue, o_ov;
    logic [AW-1:0] o_addr;
    load_cnt = 0; issue_cnt = 0; wr_cnt = 0; beat_k = 0; beat_s = 0; beats_total = 0;
    done_cnt = 0; gap_cyc = 0; stall_cyc = 0; stall_run = 0; prev_stall = 0; aborted = 0;
    start_i = 1'b1;
    s_cyc = cyc;
    tick();
    start_i = 1'b0;
    chk("first_in_ready", in_ready_o, 1);
    chk("busy_after_start", busy_o, 1);
    for (int t = 0; t < 400 && done_cnt == 0; t++) begin
      o_rdy   = in_ready_o;
      o_issue = bram_res_en_o && !bram_res_we_o;
      o_ov    = out_valid_o;
      o_addr  = bram_res_addr_o;
      if (abort && beat_s == 1 && o_issue && o_addr == 4) begin
        rst = 1'b1;
        #1;
        chk("rst_async_outs", outs, 0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          chk("rst_hold_outs", outs, 0);
          @(posedge clk);
          #1;
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_idle", outs, 0);
        @(posedge clk);
        #1;
        aborted = 1;
        break;
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      if (o_rdy) in_valid_i = (mode != 2) || ($urandom_range(3) != 0);
      else if (spurious && o_issue) in_valid_i = 1'($urandom_range(1));
      if (in_valid_i) din = 16'($urandom);
      if (o_ov) begin
        if (mode == 1) out_ready_i = !((beat_k == 2 || beat_k == 5) && stall_run < 2);
        if (mode == 2) out_ready_i = ($urandom_range(2) != 0);
        if (spurious && beat_k == 3) start_i = 1'b1;
        stall_run = out_ready_i ? 0 : stall_run + 1;
      end
      tick();
      start_i = 1'b0;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    if (!aborted) begin
      chk("done_seen", done_cnt, 1);
      chk("idle_after_done", outs, 0);
      chk("load_beats", load_cnt, N);
      chk("beats_total", beats_total, J1 * N);
      chk("done_cycle", done_cyc - s_cyc, N + gap_cyc + J1 * (2 * N + L) + stall_cyc + 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset_outs", outs, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid_i = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_release", outs, 0);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;

    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) run_frame(2, 1'($urandom_range(1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
